fe_adc_responder: RTL and testbench

- Synthesizable responder for the FE/ADC readout interface.
- It emulates the microstrip front-end daisy chain together with its serial ADCs, and answers the readout sequencer's hold, shift and ADC strobes with deterministic serial sample data.
- It sits in the tb/emulation path in place of the real FE boards, so the sequencer and its clock-divider and hold-to-shift configuration can be checked end-to-end.
- All inputs are generated from iCLK by the sequencer's dividers. The block therefore needs edge detection only, not synchronizers.

---
 rtl/fe_adc_responder.sv | 126 ++++++++++++
 tb/tb_fe_adc_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fe_adc_responder.sv
// fe_adc_responder: emulates the FE daisy chain and its serial ADCs for the readout sequencer.
// Optional bit-error injection is enabled by defining FEADC_BITERR_EN.
module fe_adc_responder #(
  parameter  int ADC_WIDTH   = 16,
  parameter  int ADC_NUM     = 10,
  parameter  int FE_CHANNELS = 64,
  parameter  int DAISY_DEPTH = 2,
  localparam int TOTAL_CH    = FE_CHANNELS * DAISY_DEPTH,
  localparam int CHW         = $clog2(TOTAL_CH + 1),
  localparam int ERRW        = (ADC_NUM > 1) ? $clog2(ADC_NUM) : 1
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iFE_HOLD,
  input  logic               iFE_SHIFT,
  input  logic               iADC_CS_N,
  input  logic               iADC_SCLK,
`ifdef FEADC_BITERR_EN
  input  logic [CHW-1:0]     iERR_CH,
  input  logic [ERRW-1:0]    iERR_ADC,
  output logic [15:0]        oERR_CNT,
`endif
  output logic [ADC_NUM-1:0] oADC_SDATA,
  output logic [CHW-1:0]     oCH_IDX,
  output logic [15:0]        oEVT_CNT,
  output logic               oOVERSHIFT
);
  typedef enum logic {EV_IDLE, EV_HELD} ev_e;
  typedef enum logic {CV_IDLE, CV_SHIFT} cv_e;
  ev_e ev_q, ev_d;
  cv_e cv_q, cv_d;
  logic hold_q, shift_q, csn_q, sclk_q;
  logic [CHW-1:0] ch_q, ch_d;
  logic [15:0] evt_q, evt_d, chx;
  logic ovs_q, ovs_d, nominal;
  logic [ADC_NUM-1:0][ADC_WIDTH-1:0] word_q, word_d, samp;
  logic hold_rise, shift_rise, cs_fall, cs_rise, sclk_fall;
  assign hold_rise  = iFE_HOLD & ~hold_q;
  assign shift_rise = iFE_SHIFT & ~shift_q;
  assign cs_fall    = ~iADC_CS_N & csn_q;
  assign cs_rise    = iADC_CS_N & ~csn_q;
  assign sclk_fall  = ~iADC_SCLK & sclk_q;
  assign chx        = 16'(ch_q);
  assign nominal    = (ev_q == EV_HELD) && (ch_q != CHW'(TOTAL_CH));
  assign oCH_IDX    = ch_q;
  assign oEVT_CNT   = evt_q;
  assign oOVERSHIFT = ovs_q;
  always_comb begin
    ev_d  = ev_q;
    ch_d  = ch_q;
    evt_d = evt_q;
    ovs_d = ovs_q;
    if (hold_rise) begin
      ev_d  = EV_HELD;
      ch_d  = '0;
      evt_d = evt_q + 16'd1;
    end else if (ev_q == EV_HELD) begin
      ev_d = iFE_HOLD ? EV_HELD : EV_IDLE;
      if (shift_rise) begin
        ovs_d = ovs_q | (ch_q == CHW'(TOTAL_CH));
        ch_d  = (ch_q == CHW'(TOTAL_CH)) ? ch_q : ch_q + CHW'(1);
      end
    end
  end
  always_comb begin
    for (int a = 0; a < ADC_NUM; a++) begin
      samp[a] = nominal ? ADC_WIDTH'({chx[7:0], 4'(a), evt_q[3:0]}) : '0;
`ifdef FEADC_BITERR_EN
      if (ch_q == iERR_CH && a == int'(iERR_ADC)) samp[a][0] = ~samp[a][0];
`endif
    end
  end
  // Word is shifted left on each SCLK fall so zeros follow bit 0 automatically.
  always_comb begin
    cv_d   = cv_q;
    word_d = word_q;
    if (cs_fall) begin
      cv_d   = CV_SHIFT;
      word_d = samp;
    end else if (cs_rise) begin
      cv_d   = CV_IDLE;
      word_d = '0;
    end else if (cv_q == CV_SHIFT && sclk_fall) begin
      for (int a = 0; a < ADC_NUM; a++) word_d[a] = word_q[a] << 1;
    end
  end
  always_comb begin
    for (int a = 0; a < ADC_NUM; a++) oADC_SDATA[a] = word_q[a][ADC_WIDTH-1];
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hold_q  <= 1'b0;
      shift_q <= 1'b0;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b1;
      ev_q    <= EV_IDLE;
      cv_q    <= CV_IDLE;
      ch_q    <= '0;
      evt_q   <= '0;
      ovs_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      hold_q  <= iFE_HOLD;
      shift_q <= iFE_SHIFT;
      csn_q   <= iADC_CS_N;
      sclk_q  <= iADC_SCLK;
      ev_q    <= ev_d;
      cv_q    <= cv_d;
      ch_q    <= ch_d;
      evt_q   <= evt_d;
      ovs_q   <= ovs_d;
      word_q  <= word_d;
    end
  end
`ifdef FEADC_BITERR_EN
  logic [15:0] err_q, err_d;
  logic err_hit;
  assign err_hit  = (ch_q == iERR_CH) && (32'(iERR_ADC) < ADC_NUM);
  assign err_d    = (cs_fall && err_hit) ? err_q + 16'd1 : err_q;
  assign oERR_CNT = err_q;
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) err_q <= '0;
    else err_q <= err_d;
  end
`endif
endmodule

// File: tb/tb_fe_adc_responder.sv
// tb_fe_adc_responder: directed and randomized checks of fe_adc_responder against an event-level model.
module tb_fe_adc_responder;
  localparam int W = 16, N = 10, TCH = 128;
  logic clk = 1'b0, rst_n = 1'b0, hold = 1'b0, shift = 1'b0, cs_n = 1'b1, sclk = 1'b1;
  logic [N-1:0] sdata;
  logic [7:0] ch;
  logic [15:0] evt, w2;
  logic ovs;
  int total = 0, bad = 0;
  bit m_held = 0, m_ovs = 0;
  int m_ch = 0, m_evt = 0;
  always #5 clk = ~clk;
  fe_adc_responder dut (
    .iCLK(clk), .iRST_N(rst_n), .iFE_HOLD(hold), .iFE_SHIFT(shift),
    .iADC_CS_N(cs_n), .iADC_SCLK(sclk), .oADC_SDATA(sdata),
    .oCH_IDX(ch), .oEVT_CNT(evt), .oOVERSHIFT(ovs)
  );
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] m_word(int a);
    return (m_held && m_ch != TCH) ? 16'((m_ch % 256) * 256 + (a % 16) * 16 + m_evt % 16) : 16'h0;
  endfunction
  task automatic m_reset();
    m_held = 0; m_ovs = 0; m_ch = 0; m_evt = 0;
  endtask
  task automatic hold_up();
    hold = 1'b1; m_held = 1; m_ch = 0; m_evt = (m_evt + 1) % 65536;
    tick(3);
  endtask
  task automatic hold_down();
    hold = 1'b0; m_held = 0;
    tick(3);
  endtask
  task automatic shift_pulse();
    shift = 1'b1;
    if (m_held) begin
      if (m_ch == TCH) m_ovs = 1;
      else m_ch++;
    end
    tick(3);
    shift = 1'b0;
    tick(3);
  endtask
  task automatic check_state(string tag);
    chk({tag, "_ch"}, 32'(ch), 32'(m_ch));
    chk({tag, "_evt"}, 32'(evt), 32'(m_evt));
    chk({tag, "_ovs"}, 32'(ovs), 32'(m_ovs));
  endtask
  task automatic convert(string tag, int falls, output logic [15:0] cap2);
    logic [N-1:0] e;
    logic [15:0] w;
    cap2 = '0;
    cs_n = 1'b0;
    tick(3);
    for (int b = 0; b < falls; b++) begin
      for (int a = 0; a < N; a++) begin
        w = m_word(a);
        e[a] = w[W-1-b];
      end
      cap2[W-1-b] = sdata[2];
      chk($sformatf("%s_bit%0d", tag, W-1-b), 32'(sdata), 32'(e));
      sclk = 1'b0;
      tick(3);
      sclk = 1'b1;
      tick(3);
    end
    if (falls == W) chk({tag, "_tail"}, 32'(sdata), 32'h0);
    cs_n = 1'b1;
    tick(1);
    chk({tag, "_csrise"}, 32'(sdata), 32'h0);
    tick(2);
  endtask
  initial begin
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(10);
      chk("rst_sdata", 32'(sdata), 32'h0);
      check_state("rst");
    end
    hold_up();
    repeat (3) shift_pulse();
    check_state("basic");
    chk("basic_ch3", 32'(ch), 32'd3);
    convert("basic", W, w2);
    chk("basic_adc2", 32'(w2), 32'h0321);
    chk("basic_evt1", 32'(evt), 32'd1);
    hold_down();
    hold = 1'b1; shift = 1'b1;
    m_held = 1; m_ch = 0; m_evt++;
    tick(3);
    shift = 1'b0;
    tick(3);
    check_state("same");
    chk("same_evt2", 32'(evt), 32'd2);
    hold_down();
    shift_pulse();
    check_state("idle_shift");
    convert("idle_conv", W, w2);
    repeat (6) begin
      hold_up();
      repeat ($urandom_range(0, 20)) shift_pulse();
      if ($urandom_range(0, 3) == 0) hold_down();
      check_state("rnd");
      convert("rnd", W, w2);
      if (m_held) hold_down();
    end
    hold_up();
    repeat (5) shift_pulse();
    convert("abort", 5, w2);
    convert("after_abort", W, w2);
    chk("after_abort_adc2", 32'(w2), 32'(m_word(2)));
    repeat (129) shift_pulse();
    check_state("sat");
    chk("sat_ch", 32'(ch), 32'd128);
    chk("sat_ovs", 32'(ovs), 32'd1);
    convert("sat_conv", W, w2);
    hold_down();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    m_reset();
    tick(2);
    check_state("rst2");
    repeat (7) begin
      hold_up();
      hold_down();
    end
    hold_up();
    m_evt = m_evt;
    repeat (2) shift_pulse();
    chk("pre_evt", 32'(evt), 32'd8);
    cs_n = 1'b0;
    tick(3);
    repeat (3) begin
      sclk = 1'b0; tick(3); sclk = 1'b1; tick(3);
    end
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("async_sdata", 32'(sdata), 32'h0);
    check_state("async");
    hold = 1'b0; shift = 1'b0; cs_n = 1'b1; sclk = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    hold_up();
    chk("post_rst_evt", 32'(evt), 32'd1);
    check_state("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
